seven_segment_scanner: RTL and testbench



---
 rtl/seven_segment_scanner_pkg.sv | 13 +
 rtl/seven_segment_slot_timer.sv | 57 +++++
 rtl/seven_segment_scanner.sv | 92 +++++++++
 tb/tb_seven_segment_scanner.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seven_segment_scanner_pkg.sv
// Segment bit order and pin constants shared by the scanner, the decoder
// and any future display blocks.
package seven_segment_scanner_pkg;
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  localparam logic [7:0] SEG_ALL_OFF_N = 8'hFF;
endpackage

// File: rtl/seven_segment_slot_timer.sv
// Slot counter and digit index for the display scanner. The *_nxt outputs
// let the parent register pin values in the same cycle the index changes.
module seven_segment_slot_timer #(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [$clog2(N_DIGITS)-1:0] idx,
  output logic [$clog2(N_DIGITS)-1:0] idx_nxt,
  output logic                        blank_nxt,
  output logic                        start_nxt,
  output logic                        frame_start
);
  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic          run;
  logic [CW-1:0] cnt, cnt_nxt;

  // The first edge after reset opens frame 0 without advancing the counter,
  // so slot 0 is a full slot and frame_start marks it like any other frame.
  always_comb begin
    cnt_nxt   = '0;
    idx_nxt   = '0;
    start_nxt = 1'b1;
    if (run) begin
      start_nxt = 1'b0;
      idx_nxt   = idx;
      if (cnt == LAST_CNT) begin
        idx_nxt   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        start_nxt = (idx == LAST_IDX);
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
    blank_nxt = (cnt_nxt < BLANK_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      run         <= 1'b1;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      frame_start <= start_nxt;
    end
  end
endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode 7-segment driver with per-frame snapshot.
// Build option LEADING_ZERO_BLANK_EN: darken zero digits above the top nonzero one.
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_bcd,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [3:0]            digit_out,
  input  logic [7:0]            seg_ah_in,
  output logic [7:0]            seg_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_start
);
  localparam int IW = $clog2(N_DIGITS);

  logic [IW-1:0]         idx, idx_nxt;
  logic                  blank_nxt, start_nxt;
  logic [4*N_DIGITS-1:0] snap_bcd, bcd_src;
  logic [N_DIGITS-1:0]   snap_dp, an_nxt, dark;
  logic [7:0]            seg_nxt;

  seven_segment_slot_timer #(
    .N_DIGITS    (N_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx        (idx),
    .idx_nxt    (idx_nxt),
    .blank_nxt  (blank_nxt),
    .start_nxt  (start_nxt),
    .frame_start(frame_start)
  );

  // On a capture edge the snapshot is being written, so digit 0 comes straight from the input.
  assign bcd_src = start_nxt ? digits_bcd : snap_bcd;

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] snap_dark, dark_nxt;

  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    dark_nxt   = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero && (digits_bcd[4*i +: 4] == 4'd0);
      dark_nxt[i] = upper_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         snap_dark <= '0;
    else if (start_nxt) snap_dark <= dark_nxt;
  end

  assign dark = snap_dark;
`else
  assign dark = '0;
`endif

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++)
      an_nxt[i] = blank_nxt || (idx_nxt != IW'(i));
    seg_nxt         = dark[idx] ? SEG_ALL_OFF_N : ~seg_ah_in;
    seg_nxt[SEG_DP] = ~snap_dp[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_bcd  <= '0;
      snap_dp   <= '0;
      digit_out <= '0;
      seg_n     <= SEG_ALL_OFF_N;
      an_n      <= '1;
    end else begin
      if (start_nxt) begin
        snap_bcd <= digits_bcd;
        snap_dp  <= dp_in;
      end
      digit_out <= bcd_src[{idx_nxt, 2'b00} +: 4];
      seg_n     <= seg_nxt;
      an_n      <= an_nxt;
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seven_segment_scanner;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [31:0] ah;    // expected active-high segments, digit 3 in the top byte
    logic [3:0]  dark;  // digits suppressed when leading-zero blanking is built in
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic       fs;
    logic [3:0] dout;
    logic       chk_seg;
    logic [7:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_bcd = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_out;
  logic [7:0]  seg_ah_in;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_start;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  vec_t cur, fr;
  vec_t vecs[8];
  int   k = 0;
  bit   started = 1'b0;

  always #5 clk = ~clk;

  seven_segment_scanner #(.N_DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .digits_bcd(digits_bcd), .dp_in(dp_in),
    .digit_out(digit_out), .seg_ah_in(seg_ah_in), .seg_n(seg_n),
    .an_n(an_n), .frame_start(frame_start)
  );

  // Decoder model; its dp bit carries junk that the scanner must override.
  function automatic logic [7:0] decode(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'd0: p = 7'h3F; 4'd1: p = 7'h06; 4'd2: p = 7'h5B; 4'd3: p = 7'h4F;
      4'd4: p = 7'h66; 4'd5: p = 7'h6D; 4'd6: p = 7'h7D; 4'd7: p = 7'h07;
      4'd8: p = 7'h7F; 4'd9: p = 7'h6F; default: p = 7'h00;
    endcase
    return {n[0], p};
  endfunction

  always_comb seg_ah_in = decode(digit_out);

  function void chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic apply(input vec_t v);
    cur        = v;
    digits_bcd = v.bcd;
    dp_in      = v.dp;
  endtask

  // Reference timeline: visible cycle k of a 32-cycle frame; captures at k == 0.
  always @(posedge clk) begin
    exp_t       e;
    logic [7:0] ah;
    int         s, p;
    if (!rst_n) begin
      started = 1'b0;
      q.delete();
    end else begin
      if (!started) begin
        started = 1'b1;
        k = 0;
      end else begin
        k = (k + 1) % 32;
      end
      if (k == 0) fr = cur;
      s = k / 8;
      p = k % 8;
      ah = fr.ah[s*8 +: 8];
      if (LZB && fr.dark[s]) ah = {ah[7], 7'b0};
      e.fs      = (k == 0);
      e.an      = (p < 2) ? 4'hF : ~(4'b0001 << s);
      e.dout    = fr.bcd[s*4 +: 4];
      e.chk_seg = (p >= 1);
      e.seg     = ~ah;
      q.push_back(e);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("an_n", {4'h0, an_n}, {4'h0, e.an});
        chk("frame_start", {7'h0, frame_start}, {7'h0, e.fs});
        chk("digit_out", {4'h0, digit_out}, {4'h0, e.dout});
        if (e.chk_seg) chk("seg_n", seg_n, e.seg);
      end
    end
  end

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 32'h065B4F66, 4'b0000};
    vecs[1] = '{16'h5678, 4'b0100, 32'h6DFD077F, 4'b0000};
    vecs[2] = '{16'h90A3, 4'b0010, 32'h6F3F804F, 4'b0000};
    vecs[3] = '{16'h0070, 4'b0000, 32'h3F3F073F, 4'b1100};
    vecs[4] = '{16'h0000, 4'b0000, 32'h3F3F3F3F, 4'b1110};
    vecs[5] = '{16'h0000, 4'b1000, 32'hBF3F3F3F, 4'b1110};
    vecs[6] = '{16'h8888, 4'b1111, 32'hFFFFFFFF, 4'b0000};
    vecs[7] = '{16'h5678, 4'b0000, 32'h6D7D077F, 4'b0000};

    apply(vecs[0]);
    repeat (2) @(negedge clk);
    chk("rst seg_n", seg_n, 8'hFF);
    chk("rst an_n", {4'h0, an_n}, 8'h0F);
    chk("rst digit_out", {4'h0, digit_out}, 8'h00);
    chk("rst frame_start", {7'h0, frame_start}, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i]);
      repeat (32) @(posedge clk);
      @(negedge clk);
    end

    // Input changes during the digit-2 slot must wait for the next frame.
    apply(vecs[0]);
    repeat (18) @(posedge clk);
    @(negedge clk);
    apply(vecs[7]);
    repeat (46) @(posedge clk);
    @(negedge clk);

    // Reset pulse mid-slot clears the pins asynchronously, then restarts at digit 0.
    repeat (11) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async seg_n", seg_n, 8'hFF);
    chk("async an_n", {4'h0, an_n}, 8'h0F);
    chk("async digit_out", {4'h0, digit_out}, 8'h00);
    chk("async frame_start", {7'h0, frame_start}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (32) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
